// File: rtl/slice_subtractor_64.sv
// 64-bit subtractor computing a + ~b + 1 one 16-bit slice per clock, LSB first.
// The result and N/Z/C/V flags are updated together when the last slice completes.
//
// state | meaning
// IDLE  | waiting for start; the result and flags hold their last values
// CALC  | one 16-bit slice per cycle, with the carry kept in carry_q
// DONE  | one-cycle done pulse; the result is already visible on diff
module slice_subtractor_64 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [63:0] a_in,
  input  logic [63:0] b_in,
  output logic [63:0] diff,
  output logic        n_flag,
  output logic        z_flag,
  output logic        c_flag,
  output logic        v_flag,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [63:0] a_q;
  logic [63:0] b_q;
  logic [1:0]  slice_idx;
  logic        carry_q;
  logic [47:0] part_q;

  logic [15:0] a_slice;
  logic [15:0] b_slice;
  logic [16:0] slice_sum;
  logic [63:0] result_full;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (slice_idx == 2'd3) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_slice = a_q[15:0];
    b_slice = b_q[15:0];
    unique case (slice_idx)
      2'd0: begin a_slice = a_q[15:0];  b_slice = b_q[15:0];  end
      2'd1: begin a_slice = a_q[31:16]; b_slice = b_q[31:16]; end
      2'd2: begin a_slice = a_q[47:32]; b_slice = b_q[47:32]; end
      2'd3: begin a_slice = a_q[63:48]; b_slice = b_q[63:48]; end
      default: ;
    endcase
    slice_sum   = {1'b0, a_slice} + {1'b0, ~b_slice} + {16'd0, carry_q};
    result_full = {slice_sum[15:0], part_q};
  end

  // busy/done come straight from flops so they cannot glitch on state decode
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      slice_idx <= 2'd0;
      carry_q   <= 1'b1;
      part_q    <= '0;
      diff      <= '0;
      n_flag    <= 1'b0;
      z_flag    <= 1'b0;
      c_flag    <= 1'b0;
      v_flag    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == CALC);
      done    <= (state_d == DONE);
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q       <= a_in;
            b_q       <= b_in;
            slice_idx <= 2'd0;
            carry_q   <= 1'b1;
          end
        end
        CALC: begin
          carry_q   <= slice_sum[16];
          slice_idx <= slice_idx + 2'd1;
          unique case (slice_idx)
            2'd0: part_q[15:0]  <= slice_sum[15:0];
            2'd1: part_q[31:16] <= slice_sum[15:0];
            2'd2: part_q[47:32] <= slice_sum[15:0];
            default: begin
              diff   <= result_full;
              n_flag <= result_full[63];
              z_flag <= (result_full == 64'd0);
              c_flag <= slice_sum[16];
              v_flag <= (a_q[63] != b_q[63]) && (result_full[63] != a_q[63]);
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slice_subtractor_64.sv
// Self-checking bench for slice_subtractor_64: directed vectors, random operands
// against an arithmetic reference, start-hold and mid-operation reset sequences.
module tb_slice_subtractor_64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic [63:0] diff;
  logic        n_flag;
  logic        z_flag;
  logic        c_flag;
  logic        v_flag;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  slice_subtractor_64 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .diff    (diff),
    .n_flag  (n_flag),
    .z_flag  (z_flag),
    .c_flag  (c_flag),
    .v_flag  (v_flag),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] diff;
    logic        n;
    logic        z;
    logic        c;
    logic        v;
  } res_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    res_t        exp;
  } vec_t;

  // Reference: plain unsigned and signed arithmetic on whole 64-bit values.
  function automatic res_t model(input logic [63:0] a, input logic [63:0] b);
    res_t r;
    logic signed [64:0] sd;
    r.diff = a - b;
    r.n    = r.diff[63];
    r.z    = (a == b);
    r.c    = (a >= b);
    sd     = $signed({a[63], a}) - $signed({b[63], b});
    r.v    = (sd > $signed({2'b00, {63{1'b1}}})) || (sd < $signed({2'b11, 63'd0}));
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_res(input string tag, input res_t e);
    check({tag, "_diff"}, diff, e.diff);
    check({tag, "_n"}, 64'(n_flag), 64'(e.n));
    check({tag, "_z"}, 64'(z_flag), 64'(e.z));
    check({tag, "_c"}, 64'(c_flag), 64'(e.c));
    check({tag, "_v"}, 64'(v_flag), 64'(e.v));
  endtask

  // Called at a negedge while idle. Scrambles the inputs after acceptance.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input string tag);
    res_t        e;
    int          cyc;
    int          bcyc;
    logic        seen;
    logic        moved;
    logic [63:0] prev;
    e     = model(a, b);
    prev  = diff;
    cyc   = 0;
    bcyc  = 0;
    seen  = 1'b0;
    moved = 1'b0;
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    do begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      a_in = {$urandom, $urandom};
      b_in = {$urandom, $urandom};
      if (done) seen = 1'b1;
      else begin
        if (busy) bcyc++;
        if (diff !== prev) moved = 1'b1;
      end
    end while (!seen && cyc < 12);
    check({tag, "_latency"}, 64'(cyc), 64'd5);
    check({tag, "_busy_cycles"}, 64'(bcyc), 64'd4);
    check({tag, "_diff_stable_in_calc"}, 64'(moved), 64'd0);
    check_res(tag, e);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_diff_hold"}, diff, e.diff);
  endtask

  vec_t vecs[6];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] a1, b1, a2, b2, ra, rb;
    int          cyc;
    logic        seen;

    vecs[0] = '{64'd10, 64'd3, '{64'd7, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[1] = '{64'd0, 64'd1, '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'd1, '{64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1}};
    vecs[3] = '{64'd5, 64'd5, '{64'd0, 1'b0, 1'b1, 1'b1, 1'b0}};
    vecs[4] = '{64'h0000_0001_0000_0000, 64'd1, '{64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[5] = '{64'd1, 64'h8000_0000_0000_0000, '{64'h8000_0000_0000_0001, 1'b1, 1'b0, 1'b0, 1'b1}};

    reset_n = 1'b0;
    start   = 1'b0;
    a_in    = '0;
    b_in    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_diff", diff, 64'd0);
    check("rst_ctrl_flags", {58'd0, n_flag, z_flag, c_flag, v_flag, busy, done}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      ra = {$urandom, $urandom};
      rb = (i % 5 == 0) ? ra : {$urandom, $urandom};
      run_op(ra, rb, $sformatf("rnd%0d", i));
    end

    // start held high, operands changing every cycle
    a1 = {$urandom, $urandom};
    b1 = {$urandom, $urandom};
    start = 1'b1;
    a_in  = a1;
    b_in  = b1;
    cyc   = 0;
    seen  = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      a_in = {$urandom, $urandom};
      b_in = {$urandom, $urandom};
      seen = done;
    end while (!seen && cyc < 12);
    check("hold_latency", 64'(cyc), 64'd5);
    check_res("hold_first", model(a1, b1));
    @(negedge clk);
    check("hold_idle_gap", 64'(busy), 64'd0);
    a2   = {$urandom, $urandom};
    b2   = {$urandom, $urandom};
    a_in = a2;
    b_in = b2;
    @(negedge clk);
    check("hold_reaccept", 64'(busy), 64'd1);
    start = 1'b0;
    cyc   = 1;
    seen  = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      a_in = {$urandom, $urandom};
      seen = done;
    end while (!seen && cyc < 12);
    check("hold2_latency", 64'(cyc), 64'd5);
    check_res("hold_second", model(a2, b2));
    @(negedge clk);

    // reset in the second CALC cycle aborts the operation
    start = 1'b1;
    a_in  = 64'd10;
    b_in  = 64'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_diff", diff, 64'd0);
    check("abort_ctrl_flags", {58'd0, n_flag, z_flag, c_flag, v_flag, busy, done}, 64'd0);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    run_op(64'd10, 64'd3, "post_abort");

    // start coincident with reset is lost
    reset_n = 1'b0;
    start   = 1'b1;
    a_in    = 64'd9;
    b_in    = 64'd4;
    @(negedge clk);
    reset_n = 1'b1;
    start   = 1'b0;
    check("rst_start_busy0", 64'(busy), 64'd0);
    @(negedge clk);
    check("rst_start_busy1", 64'(busy), 64'd0);
    check("rst_start_diff", diff, 64'd0);
    run_op(64'd9, 64'd4, "post_rst_start");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
